// File: rtl/key_codes_pkg.sv
// Scan-code set 2 constants, decoder state encoding and held_dir bit positions
// shared by the key event decoder and its prefix timer.
package key_codes_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    // One-hot held_dir position of an extended arrow code, zero if not an arrow.
    function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
        logic [3:0] oh;
        oh = '0;
        case (code)
            SC_UP:    oh[DIR_UP]    = 1'b1;
            SC_DOWN:  oh[DIR_DOWN]  = 1'b1;
            SC_LEFT:  oh[DIR_LEFT]  = 1'b1;
            SC_RIGHT: oh[DIR_RIGHT] = 1'b1;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic [3:0] wasd_onehot(input logic [7:0] code);
        logic [3:0] oh;
        oh = '0;
        case (code)
            SC_W:    oh[DIR_UP]    = 1'b1;
            SC_S:    oh[DIR_DOWN]  = 1'b1;
            SC_A:    oh[DIR_LEFT]  = 1'b1;
            SC_D:    oh[DIR_RIGHT] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/prefix_timer.sv
// Idle counter for a pending E0/F0 prefix: expired is a combinational pulse in the
// cycle the count sits at PREFIX_TIMEOUT-1 with no new byte; restart/!enable reload 0.
module prefix_timer #(
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(PREFIX_TIMEOUT - 1);

    logic [W-1:0] cnt;

    // A byte arriving in the expiry cycle still completes the pending sequence.
    assign expired = enable && !restart && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !enable || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// PS/2 set-2 byte stream to held-key levels and one-shot Space/Enter press pulses.
// Outputs registered, 1 cycle after the final byte; KEY_DECODER_WASD_EN adds WASD.
module key_event_decoder #(
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       clear,
    output logic [3:0] held_dir,
    output logic       space_held,
    output logic       space_pressed,
    output logic       start_pressed
);

    import key_codes_pkg::*;

    dec_state_t state, state_nxt;
    logic [3:0] arrow_q, arrow_nxt;
    logic       space_nxt, enter_q, enter_nxt;
    logic       space_pulse_nxt, start_pulse_nxt;
    logic       done, is_ext, is_brk, expired;
`ifdef KEY_DECODER_WASD_EN
    logic [3:0] wasd_q, wasd_nxt;
`endif

    prefix_timer #(
        .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
    ) u_prefix_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (scan_valid | clear),
        .enable  (state != ST_IDLE),
        .expired (expired)
    );

    always_comb begin
        state_nxt       = state;
        arrow_nxt       = arrow_q;
        space_nxt       = space_held;
        enter_nxt       = enter_q;
        space_pulse_nxt = 1'b0;
        start_pulse_nxt = 1'b0;
        done            = 1'b0;
        is_ext          = 1'b0;
        is_brk          = 1'b0;
`ifdef KEY_DECODER_WASD_EN
        wasd_nxt        = wasd_q;
`endif
        if (clear) begin
            state_nxt = ST_IDLE;
            arrow_nxt = '0;
            space_nxt = 1'b0;
            enter_nxt = 1'b0;
`ifdef KEY_DECODER_WASD_EN
            wasd_nxt  = '0;
`endif
        end else if (scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)      state_nxt = ST_EXT;
                    else if (scan_code == SC_BRK) state_nxt = ST_BRK;
                    else                          done = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == SC_BRK)      state_nxt = ST_EXT_BRK;
                    else if (scan_code != SC_EXT) begin
                        done   = 1'b1;
                        is_ext = 1'b1;
                    end
                end
                ST_BRK: begin
                    // E0 after F0 is malformed; treat it as the start of an extended code.
                    if (scan_code == SC_EXT)      state_nxt = ST_EXT;
                    else if (scan_code != SC_BRK) begin
                        done   = 1'b1;
                        is_brk = 1'b1;
                    end
                end
                default: begin
                    if (scan_code != SC_EXT && scan_code != SC_BRK) begin
                        done   = 1'b1;
                        is_ext = 1'b1;
                        is_brk = 1'b1;
                    end
                end
            endcase
            if (done) state_nxt = ST_IDLE;
        end else if (expired) begin
            state_nxt = ST_IDLE;
        end

        if (done) begin
            if (is_ext) begin
                arrow_nxt = is_brk ? (arrow_q & ~arrow_onehot(scan_code))
                                   : (arrow_q |  arrow_onehot(scan_code));
            end else begin
                case (scan_code)
                    SC_SPACE: begin
                        space_pulse_nxt = !is_brk && !space_held;
                        space_nxt       = !is_brk;
                    end
                    SC_ENTER: begin
                        start_pulse_nxt = !is_brk && !enter_q;
                        enter_nxt       = !is_brk;
                    end
                    default: begin
`ifdef KEY_DECODER_WASD_EN
                        wasd_nxt = is_brk ? (wasd_q & ~wasd_onehot(scan_code))
                                          : (wasd_q |  wasd_onehot(scan_code));
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            arrow_q       <= '0;
            space_held    <= 1'b0;
            enter_q       <= 1'b0;
            space_pressed <= 1'b0;
            start_pressed <= 1'b0;
`ifdef KEY_DECODER_WASD_EN
            wasd_q        <= '0;
`endif
        end else begin
            state         <= state_nxt;
            arrow_q       <= arrow_nxt;
            space_held    <= space_nxt;
            enter_q       <= enter_nxt;
            space_pressed <= space_pulse_nxt;
            start_pressed <= start_pulse_nxt;
`ifdef KEY_DECODER_WASD_EN
            wasd_q        <= wasd_nxt;
`endif
        end
    end

`ifdef KEY_DECODER_WASD_EN
    assign held_dir = arrow_q | wasd_q;
`else
    assign held_dir = arrow_q;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed scenarios plus random byte streams, each cycle compared against a
// prefix-flag / key-set reference model.
module tb_key_event_decoder;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       clear = 1'b0;
    logic [3:0] held_dir;
    logic       space_held, space_pressed, start_pressed;

    int vectors = 0;
    int miscompares = 0;
    int start_seen = 0;

    // reference model: pending prefix as two flags, keys as plain sets
    bit       m_ext, m_brk;
    int       m_idle;
    bit [3:0] m_arrow, m_wasd;
    bit       m_space, m_enter, m_sp_p, m_st_p;

    always #5 clk = ~clk;

    key_event_decoder #(.PREFIX_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_valid    (scan_valid),
        .scan_code     (scan_code),
        .clear         (clear),
        .held_dir      (held_dir),
        .space_held    (space_held),
        .space_pressed (space_pressed),
        .start_pressed (start_pressed)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_idle = 0;
        m_arrow = '0; m_wasd = '0;
        m_space = 0; m_enter = 0; m_sp_p = 0; m_st_p = 0;
    endfunction

    function automatic int dir_of(input logic [7:0] c, input bit wasd);
        if (!wasd) begin
            if (c == 8'h75) return 3;
            if (c == 8'h72) return 2;
            if (c == 8'h6B) return 1;
            if (c == 8'h74) return 0;
        end else begin
            if (c == 8'h1D) return 3;
            if (c == 8'h1B) return 2;
            if (c == 8'h1C) return 1;
            if (c == 8'h23) return 0;
        end
        return -1;
    endfunction

    function automatic void model_key(input logic [7:0] c, input bit ext, input bit brk);
        int d;
        if (ext) begin
            d = dir_of(c, 1'b0);
            if (d >= 0) m_arrow[d] = !brk;
        end else if (c == 8'h29) begin
            if (!brk && !m_space) m_sp_p = 1;
            m_space = !brk;
        end else if (c == 8'h5A) begin
            if (!brk && !m_enter) m_st_p = 1;
            m_enter = !brk;
        end else begin
`ifdef KEY_DECODER_WASD_EN
            d = dir_of(c, 1'b1);
            if (d >= 0) m_wasd[d] = !brk;
`endif
        end
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] c, input bit clr);
        m_sp_p = 0;
        m_st_p = 0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            m_idle = 0;
            if (c == 8'hE0) begin
                if (!(m_ext && m_brk)) begin m_ext = 1; m_brk = 0; end
            end else if (c == 8'hF0) begin
                m_brk = 1;
            end else begin
                model_key(c, m_ext, m_brk);
                m_ext = 0;
                m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle >= T) begin m_ext = 0; m_brk = 0; m_idle = 0; end
        end
    endfunction

    task automatic check_all();
        check_eq("held_dir", 32'(held_dir), 32'(m_arrow | m_wasd));
        check_eq("space_held", 32'(space_held), 32'(m_space));
        check_eq("space_pressed", 32'(space_pressed), 32'(m_sp_p));
        check_eq("start_pressed", 32'(start_pressed), 32'(m_st_p));
    endtask

    task automatic tick(input bit v, input logic [7:0] c, input bit clr);
        scan_valid = v;
        scan_code  = c;
        clear      = clr;
        @(posedge clk);
        model_step(v, c, clr);
        @(negedge clk);
        check_all();
        if (start_pressed) start_seen++;
        scan_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        tick(1'b1, c, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4:       return 8'h29;
            5:       return 8'h5A;
            6:       return 8'h75;
            7:       return 8'h72;
            8:       return 8'h6B;
            9:       return 8'h74;
            10:      return 8'h1D;
            11:      return 8'h1B;
            12:      return 8'h1C;
            13:      return 8'h23;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        model_reset();
        #1;
        check_eq("rst_dir", 32'(held_dir), 32'h0);
        check_eq("rst_space", 32'(space_held), 32'h0);
        check_eq("rst_pulses", 32'({space_pressed, start_pressed}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Space make / break
        send(8'h29);
        check_eq("space_make_pulse", 32'(space_pressed), 32'h1);
        idle(1);
        check_eq("space_pulse_width", 32'(space_pressed), 32'h0);
        send(8'hF0); send(8'h29);
        check_eq("space_break", 32'(space_held), 32'h0);

        // typematic Enter
        start_seen = 0;
        send(8'h5A); send(8'h5A); send(8'h5A);
        send(8'hF0); send(8'h5A);
        send(8'h5A);
        idle(1);
        check_eq("enter_pulse_count", 32'(start_seen), 32'd2);
        send(8'hF0); send(8'h5A);

        // arrows
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
        check_eq("arrows_up_left", 32'(held_dir), 32'b1010);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_eq("arrow_up_break", 32'(held_dir), 32'b0010);
        send(8'hE0); send(8'hF0); send(8'h6B);

        // prefix timeout boundary
        send(8'hE0); idle(T - 1); send(8'h75);
        check_eq("prefix_survives", 32'(held_dir), 32'b1000);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); idle(T); send(8'h75);
        check_eq("prefix_expired", 32'(held_dir), 32'b0000);
        send(8'hE0); idle(20); send(8'h75);
        check_eq("prefix_expired_long", 32'(held_dir), 32'b0000);

        // clear beats a coincident byte
        send(8'h29);
        tick(1'b1, 8'h29, 1'b1);
        check_eq("clear_space", 32'(space_held), 32'h0);
        check_eq("clear_no_pulse", 32'(space_pressed), 32'h0);
        send(8'h29);
        check_eq("after_clear_pulse", 32'(space_pressed), 32'h1);

`ifdef KEY_DECODER_WASD_EN
        send(8'h1D); send(8'hE0); send(8'h75); send(8'hF0); send(8'h1D);
        check_eq("wasd_or_up", 32'(held_dir[3]), 32'h1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_eq("wasd_up_released", 32'(held_dir[3]), 32'h0);
`endif

        // asynchronous reset mid-sequence
        send(8'hE0); send(8'h72); send(8'hE0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_dir", 32'(held_dir), 32'h0);
        check_eq("async_rst_space", 32'(space_held), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h75);
        check_eq("lost_prefix", 32'(held_dir), 32'h0);

        // randomized streams
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       tick(1'($urandom_range(0, 1)), pick(), 1'b1);
            else if (r < 4)  idle($urandom_range(T - 2, T + 2));
            else if (r < 60) send(pick());
            else             tick(1'b0, 8'h00, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Converts the raw PS/2 scan-code byte stream from the keyboard receiver into clean game inputs: direction-held levels and single-cycle edge pulses for Space (`space_pressed`) and Enter (`start_pressed`). It sits directly upstream of the top-level game state machine and player/attack sprites. It handles scan-code set 2 make/break/extended prefixes and suppresses typematic auto-repeat, so one physical press yields exactly one pulse.

## Interface
- `PREFIX_TIMEOUT`, default 1_000_000: cycles a pending prefix (E0/F0) may wait for its next byte before being discarded.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `scan_valid`  in  1  one-cycle strobe: `scan_code` holds a new received byte.
- `scan_code`  in  8  received scan-code byte.
- `clear`  in  1  synchronous flush: drop the pending prefix and release all held keys.
- `held_dir`  out  4  level, {up, down, left, right}; 1 while the key is down.
- `space_held`  out  1  level, Space currently down.
- `space_pressed`  out  1  one-cycle pulse on a Space press.
- `start_pressed`  out  1  one-cycle pulse on an Enter press.

## Operation
- Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: E0→EXT; F0→BRK; any other byte is a make code, decoded, →IDLE.
- EXT: F0→EXT_BRK; E0→EXT; other byte is an extended make, →IDLE.
- BRK: F0→BRK; E0→EXT (malformed sequence, restart as extended); other byte is a break, →IDLE.
- EXT_BRK: E0/F0→EXT_BRK; other byte is an extended break, →IDLE.
- Recognised keys: extended 75 up, 72 down, 6B left, 74 right; plain 29 Space, 5A Enter. Any other completed code is consumed with no effect.
- Make sets the key's held flag. Break clears it.
- Pulse rule: `space_pressed`/`start_pressed` fire only when a make arrives while that key's held flag is 0. Repeated makes while held produce no pulse.
- The held flag for Enter is internal; it is not an output.
- A break for a key that is not held is a no-op.
- Prefix timeout: the counter reloads to 0 on every `scan_valid`. In any non-IDLE state, reaching `PREFIX_TIMEOUT-1` forces IDLE and discards the prefix. Held flags are unchanged.
- `clear`: FSM→IDLE, all held flags→0, counter→0, pulses suppressed that cycle. If `clear` and `scan_valid` coincide, `clear` wins and the byte is dropped.

## Timing
- Reset values: FSM IDLE, counter 0, all held flags and all outputs 0.
- Latency: the held/pulse outputs update on the clock edge after the `scan_valid` cycle carrying the final byte. That is 1 cycle, and outputs are registered.
- Pulses are exactly 1 clk wide.
- Back-to-back `scan_valid` on consecutive cycles is supported, with each byte processed in order.
- Asynchronous reset mid-sequence returns everything to the reset values immediately. Bytes of a partially received sequence are lost.

## Configuration
- `KEY_DECODER_WASD_EN`: when defined, plain codes 1D (W), 1B (S), 1C (A), 23 (D) get their own held flags. Each `held_dir` bit is then the OR of the arrow flag and the matching WASD flag. A bit clears only when both keys are released.
- When undefined, WASD codes are consumed with no effect.

## Structure
- Package `key_codes_pkg`:
  - scan-code constants (prefixes E0/F0 and all key codes above);
  - FSM state enum;
  - `held_dir` bit-index constants.
- Sub-module `prefix_timer`: the timeout counter, with `restart` and `enable` inputs and an `expired` pulse output. The width is derived from `PREFIX_TIMEOUT` by `$clog2`.
- All decode logic and held flags live in `key_event_decoder`.

## Test plan
- Reset, then bytes 29 → `space_pressed` high 1 cycle after the strobe, and `space_held`=1. Then bytes F0 29 → `space_held`=0, with no pulse.
- Bytes 5A 5A 5A (typematic), then F0 5A, then 5A → exactly two `start_pressed` pulses: the first after the first 5A, the second after the final 5A.
- Bytes E0 75, E0 6B → `held_dir`=4'b1010. Then E0 F0 75 → `held_dir`=4'b0010.
- With `PREFIX_TIMEOUT`=16: byte E0, idle 20 cycles, then 75 → `held_dir` unchanged and FSM in IDLE after the timeout. The late 75 is treated as a plain unknown code with no effect.
- Space held, then `clear` asserted in the same cycle as `scan_valid` with 29 → `space_held`=0, no pulse, byte dropped. The next 29 produces a pulse.
- With `KEY_DECODER_WASD_EN`: bytes 1D, then E0 75, then F0 1D → up stays 1. Then E0 F0 75 → up=0.
